reg_out_fifo: RTL
=================

Name: reg_out_fifo

Overview:
Downstream capture stage for the WIDTH-bit enable-gated register. Each cycle the register's enable was asserted, the register's new output value is pushed into a small show-ahead FIFO. The FIFO drains through a valid/ready handshake to the checker/scoreboard-side logic, so no register update is lost when the consumer stalls. Reports fill level and a sticky overflow flag.

Parameters:
WIDTH, 8, data width; must equal the upstream register's WIDTH
DEPTH, 4, FIFO entries; power of two, >= 2
CNT_W, $clog2(DEPTH+1), width of the count output (derived; not overridden)

Ports:
clk  input  1  rising-edge clock shared with the upstream register
reset_n  input  1  asynchronous, active-low reset
in_valid  input  1  push strobe; the upstream enable delayed one cycle, aligned with the updated register output
in_data  input  WIDTH  upstream register output (outa)
clr  input  1  synchronous flush
out_valid  output  1  head entry available
out_ready  input  1  consumer accepts the head entry
out_data  output  WIDTH  head entry (show-ahead)
count  output  CNT_W  number of occupied entries, 0..DEPTH
full  output  1  count == DEPTH
empty  output  1  count == 0
overflow  output  1  sticky; a push was dropped

Behaviour:
- Reset (reset_n=0, async): wr_ptr=rd_ptr=0, count=0, overflow=0, all storage=0. Outputs: out_valid=0, out_data=0, full=0, empty=1. Any contents present when reset asserts are discarded, including reset asserted mid-stream.
- Pop = out_valid & out_ready. Push = in_valid & (!full | pop).
- Push writes in_data to mem[wr_ptr]. wr_ptr increments mod DEPTH. Pop increments rd_ptr mod DEPTH. Pointers are log2(DEPTH) bits and wrap naturally.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Simultaneous push and pop when full: both happen and count stays DEPTH. Simultaneous push and pop when empty: pop is impossible (out_valid=0), so only the push occurs. No bypass; data appears on out_data the next cycle.
- Latency: in_valid at edge N makes out_valid=1 and out_data=in_data after edge N (1 cycle).
- out_valid = !empty. out_data = mem[rd_ptr], held stable while out_valid & !out_ready.
- Drop: in_valid & full & !pop. Data is discarded, no state changes except overflow<=1. overflow stays set until clr or reset.
- clr=1: ptrs<=0, count<=0, overflow<=0. clr overrides push/pop in the same cycle. Storage is not cleared.
- out_ready while empty is ignored.
- full and empty are decoded from count (registered state), so they are glitch-free.
- No X propagation: all registers reset. count never exceeds DEPTH and never underflows. Assertions are required for both.

Test Plan:
- Reset, then push 0xA5 with out_ready=0 -> next cycle out_valid=1, out_data=0xA5, count=1, empty=0; holds steady over 5 cycles.
- Push 0x01,0x02,0x03,0x04 back-to-back with out_ready=0 (DEPTH=4) -> full=1, count=4. Push 0x05 -> overflow=1, count=4. Drain with out_ready=1 -> 0x01..0x04 in order, then empty=1, and overflow stays 1.
- Full FIFO with in_valid=1 (0x10) and out_ready=1 in the same cycle -> count stays 4, overflow=0, and 0x10 emerges after the three older entries.
- Continuous push/pop with out_ready=1 over 10 values 0x00..0x09 -> pointer wrap is exercised and output order matches input order, each value one cycle after its push.
- Mid-stream (count=3), assert clr together with in_valid=1 -> next cycle count=0, empty=1, out_valid=0, overflow=0; the pushed value is lost.
- Assert reset_n=0 asynchronously between edges with count=2 -> out_valid, count, overflow and out_data drop to 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/reg_out_fifo.sv
// Show-ahead capture FIFO behind the enable-gated register: every enabled update is queued
// and drained over valid/ready, with fill level and a sticky overflow flag.
module reg_out_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             overflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             overflow_reg, overflow_next;
    logic             push, pop, drop;

    assign full      = (count_reg == FULL_CNT);
    assign empty     = (count_reg == '0);
    assign out_valid = !empty;
    assign out_data  = mem_reg[rd_ptr_reg];
    assign count     = count_reg;
    assign overflow  = overflow_reg;

    // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
    assign pop  = out_valid & out_ready;
    assign push = in_valid & (!full | pop);
    assign drop = in_valid & full & !pop;

    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg;
        overflow_next = overflow_reg;
        if (clr) begin
            wr_ptr_next   = '0;
            rd_ptr_next   = '0;
            count_next    = '0;
            overflow_next = 1'b0;
        end else begin
            if (push)
                wr_ptr_next = wr_ptr_reg + PTR_W'(1);
            if (pop)
                rd_ptr_next = rd_ptr_reg + PTR_W'(1);
            if (push && !pop)
                count_next = count_reg + CNT_W'(1);
            else if (pop && !push)
                count_next = count_reg - CNT_W'(1);
            if (drop)
                overflow_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
        end
    end

    // Storage is zeroed only by reset; a flush just rewinds the pointers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem_reg[i] <= '0;
        end else if (push && !clr) begin
            mem_reg[wr_ptr_reg] <= in_data;
        end
    end

`ifndef SYNTHESIS
    count_le_depth: assert property (@(posedge clk) disable iff (!reset_n) count_reg <= FULL_CNT);
    no_underflow:   assert property (@(posedge clk) disable iff (!reset_n) pop |-> count_reg != '0);
`endif

endmodule
